// File: rtl/product_serializer.sv
// product_serializer - captures a WIDTH-bit result word and shifts it out one bit per valid/ready transfer.
// One pending slot lets the next word queue behind the word that is shifting.
module product_serializer #(
  parameter int WIDTH     = 37,
  parameter bit MSB_FIRST = 1'b0,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] par_data,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_data,
  output logic             ser_last,
  output logic             busy,
  output logic [CNT_W-1:0] words_sent
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_IDX = BW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [WIDTH-1:0] pend, pend_nxt;
  logic             pend_valid, pend_valid_nxt;
  logic [BW-1:0]    bit_cnt, bit_cnt_nxt;
  logic [CNT_W-1:0] words_sent_nxt;
  logic             load_acc, xfer, last_bit;

  assign load_ready = !pend_valid;
  assign load_acc   = load_valid && load_ready;
  assign ser_valid  = (state == SHIFT);
  assign last_bit   = (bit_cnt == LAST_IDX);
  assign ser_data   = ser_valid && (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);
  assign ser_last   = ser_valid && last_bit;
  assign xfer       = ser_valid && ser_ready;
  assign busy       = ser_valid || pend_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shreg      <= '0;
      pend       <= '0;
      pend_valid <= 1'b0;
      bit_cnt    <= '0;
      words_sent <= '0;
    end else begin
      state      <= state_nxt;
      shreg      <= shreg_nxt;
      pend       <= pend_nxt;
      pend_valid <= pend_valid_nxt;
      bit_cnt    <= bit_cnt_nxt;
      words_sent <= words_sent_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    shreg_nxt      = shreg;
    pend_nxt       = pend;
    pend_valid_nxt = pend_valid;
    bit_cnt_nxt    = bit_cnt;
    words_sent_nxt = words_sent;
    case (state)
      IDLE: begin
        if (load_acc) begin
          shreg_nxt   = par_data;
          bit_cnt_nxt = '0;
          state_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        if (xfer && last_bit) begin
          // Refill from the pending slot first, then a same-cycle load, so words run back to back.
          words_sent_nxt = words_sent + 1'b1;
          bit_cnt_nxt    = '0;
          if (pend_valid) begin
            shreg_nxt      = pend;
            pend_valid_nxt = 1'b0;
          end else if (load_acc) begin
            shreg_nxt = par_data;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          if (xfer) begin
            shreg_nxt   = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
            bit_cnt_nxt = bit_cnt + 1'b1;
          end
          if (load_acc) begin
            pend_nxt       = par_data;
            pend_valid_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_product_serializer.sv
// tb_product_serializer - randomized bench with a bit-queue reference model for product_serializer.
module tb_product_serializer;

  localparam int WIDTH = 37;
  localparam int CNT_W = 16;

  logic             clk, rst_n;
  logic             load_valid, load_ready, ser_valid, ser_ready, ser_data, ser_last, busy;
  logic [WIDTH-1:0] par_data;
  logic [CNT_W-1:0] words_sent;
  logic             load_valid_m, load_ready_m, ser_valid_m, ser_ready_m, ser_data_m, ser_last_m, busy_m;
  logic [WIDTH-1:0] par_data_m;
  logic [CNT_W-1:0] words_sent_m;

  product_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
    .par_data(par_data), .ser_valid(ser_valid), .ser_ready(ser_ready), .ser_data(ser_data),
    .ser_last(ser_last), .busy(busy), .words_sent(words_sent));

  product_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1), .CNT_W(CNT_W)) dut_m (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid_m), .load_ready(load_ready_m),
    .par_data(par_data_m), .ser_valid(ser_valid_m), .ser_ready(ser_ready_m), .ser_data(ser_data_m),
    .ser_last(ser_last_m), .busy(busy_m), .words_sent(words_sent_m));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: expected bit stream in transmit order, words in flight, words completed.
  typedef struct {logic b; logic last;} ebit_t;
  ebit_t q[$];
  int    inflight = 0;
  int    sent = 0;
  bit    chk_en = 0;

  task automatic model_clear();
    q.delete();
    inflight = 0;
    sent = 0;
  endtask

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("ser_valid", 64'(ser_valid), 64'(inflight > 0));
      chk("load_ready", 64'(load_ready), 64'(inflight < 2));
      chk("busy", 64'(busy), 64'(inflight > 0));
      chk("words_sent", 64'(words_sent), 64'(sent % (1 << CNT_W)));
      if (ser_valid && q.size() > 0) begin
        chk("ser_data", 64'(ser_data), 64'(q[0].b));
        chk("ser_last", 64'(ser_last), 64'(q[0].last));
      end
      if (load_valid && inflight < 2) begin
        for (int i = 0; i < WIDTH; i++) q.push_back('{par_data[i], i == WIDTH - 1});
        inflight++;
      end
      if (ser_valid && ser_ready && q.size() > 0) begin
        if (q[0].last) begin
          sent++;
          inflight--;
        end
        void'(q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [WIDTH-1:0] w);
    logic acc;
    int   n;
    n = 0;
    load_valid = 1'b1;
    par_data = w;
    do begin
      acc = load_ready;
      step();
      n++;
    end while (!acc && n < 500);
    load_valid = 1'b0;
    if (!acc) chk("load_timeout", 64'(0), 64'(1));
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 400 && busy; i++) step();
    chk(tag, 64'(busy), 64'(0));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_valid"}, 64'(ser_valid), 64'(0));
    chk({tag, "_data"}, 64'(ser_data), 64'(0));
    chk({tag, "_last"}, 64'(ser_last), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_lready"}, 64'(load_ready), 64'(1));
    chk({tag, "_sent"}, 64'(words_sent), 64'(0));
    chk({tag, "_m_valid"}, 64'(ser_valid_m), 64'(0));
    chk({tag, "_m_sent"}, 64'(words_sent_m), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic             acc;
    logic [WIDTH-1:0] w;
    int               n;
    clk = 0; rst_n = 1;
    load_valid = 0; par_data = '0; ser_ready = 0;
    load_valid_m = 0; par_data_m = '0; ser_ready_m = 0;
    #1 rst_n = 0;
    #1 check_reset("rst0");
    @(posedge clk); #1 rst_n = 1;
    chk_en = 1;

    // LSB-first single word
    ser_ready = 1;
    load_word(37'h1_2345_6789);
    wait_idle("t1_drain");
    chk("t1_sent", 64'(words_sent), 64'(1));

    // second word queued while the first shifts
    load_word(37'h1F_FFFF_FFFF);
    step(); step();
    load_word(37'h0_0000_0001);
    chk("t2_lready", 64'(load_ready), 64'(0));
    wait_idle("t2_drain");

    // pending slot full with load held, then a load on the last-bit cycle
    load_word(37'h0A_5A5A_5A5A);
    load_word(37'h15_A5A5_A5A5);
    load_word(37'h03_0F0F_0F0F);
    wait_idle("t4_drain");
    load_word(37'h12_3456_789A);
    n = 0;
    while (!(ser_valid && ser_last) && n < 100) begin step(); n++; end
    chk("t4_lastseen", 64'(ser_last), 64'(1));
    load_valid = 1'b1;
    par_data = 37'h0C_CCCC_CCCC;
    step();
    load_valid = 1'b0;
    chk("t4_nobubble", 64'(ser_valid), 64'(1));
    wait_idle("t4_drain2");

    // random stall and load traffic
    for (int c = 0; c < 3000; c++) begin
      acc = load_valid && load_ready;
      ser_ready = 1'($urandom % 2);
      step();
      if (acc) load_valid = 1'b0;
      if (!load_valid && ($urandom % 3 == 0)) begin
        load_valid = 1'b1;
        par_data = WIDTH'({$urandom, $urandom});
      end
    end
    ser_ready = 1;
    n = 0;
    while (load_valid && n < 200) begin
      acc = load_ready;
      step();
      if (acc) load_valid = 1'b0;
      n++;
    end
    wait_idle("t3_drain");

    // reset mid-word with a word pending
    load_word(37'h1E_1234_5678);
    load_word(37'h01_8765_4321);
    for (int i = 0; i < 18; i++) step();
    chk("t6_pending", 64'(load_ready), 64'(0));
    chk_en = 0;
    #2 rst_n = 0;
    #1 check_reset("t6_rst");
    model_clear();
    @(posedge clk); #1 rst_n = 1;
    chk_en = 1;
    load_word(37'h00_0000_0003);
    wait_idle("t6_drain");
    chk("t6_sent", 64'(words_sent), 64'(1));

    // MSB-first instance
    w = 37'h10_0000_0000;
    ser_ready_m = 1;
    load_valid_m = 1;
    par_data_m = w;
    step();
    load_valid_m = 0;
    for (int i = 0; i < WIDTH; i++) begin
      chk("t5_valid", 64'(ser_valid_m), 64'(1));
      chk("t5_data", 64'(ser_data_m), 64'(w[WIDTH-1-i]));
      chk("t5_last", 64'(ser_last_m), 64'(i == WIDTH - 1));
      step();
    end
    chk("t5_idle", 64'(ser_valid_m), 64'(0));
    chk("t5_sent", 64'(words_sent_m), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
